// File: rtl/servo_pkg.sv
// Shared types, constants and the slew helper for the gesture servo driver.
//   NUM_CH     : servo channel count (fixed at 5, one per finger)
//   pos_us_t   : pulse width / position in microseconds (12 bits)
//   frame_us_t : microsecond position inside a PWM frame (15 bits)
//   HOLD_BIT   : gesture bit that marks a hold code (no target change)
//   slew_step  : moves pos toward tgt by at most step, never past tgt
package servo_pkg;

  localparam int unsigned NUM_CH   = 5;
  localparam int unsigned POS_W    = 12;
  localparam int unsigned FRAME_W  = 15;
  localparam int unsigned HOLD_BIT = 7;

  typedef logic [POS_W-1:0]   pos_us_t;
  typedef logic [FRAME_W-1:0] frame_us_t;

  // Signed 13-bit difference so both directions compare against the limit.
  function automatic pos_us_t slew_step(input pos_us_t pos,
                                        input pos_us_t tgt,
                                        input pos_us_t step);
    logic signed [POS_W:0] diff;
    logic signed [POS_W:0] lim;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, pos});
    lim  = $signed({1'b0, step});
    if (diff > lim) begin
      slew_step = pos + step;
    end else if (diff < -lim) begin
      slew_step = pos - step;
    end else begin
      slew_step = tgt;
    end
  endfunction

endpackage

// File: rtl/servo_pwm_channel.sv
// One servo channel: holds the current position, moves it toward the target
// once per frame, and produces a registered PWM bit from the shared us count.
//   clk, rst_n   : clock, synchronous active-low reset
//   i_frame_tick : one-cycle frame boundary pulse
//   i_tgt        : effective target for this frame boundary
//   i_us_cnt     : shared microsecond counter within the frame
//   o_pos        : current position (registered)
//   o_pwm        : PWM output, high while us count < position (registered)
module servo_pwm_channel
  import servo_pkg::*;
#(
  parameter int unsigned MIN_US  = 1000,
  parameter int unsigned MAX_US  = 2000,
  parameter int unsigned STEP_US = 20
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_frame_tick,
  input  pos_us_t   i_tgt,
  input  frame_us_t i_us_cnt,
  output pos_us_t   o_pos,
  output logic      o_pwm
);

  localparam pos_us_t MIN_P  = pos_us_t'(MIN_US);
  localparam pos_us_t MAX_P  = pos_us_t'(MAX_US);
  localparam pos_us_t STEP_P = pos_us_t'(STEP_US);

  pos_us_t r_pos;
  logic    r_pwm;
  pos_us_t w_step;
  pos_us_t w_next;

  // Slew toward target, then clamp into the legal pulse range.
  always_comb begin
    w_step = slew_step(r_pos, i_tgt, STEP_P);
    w_next = w_step;
    if (w_step < MIN_P) begin
      w_next = MIN_P;
    end else if (w_step > MAX_P) begin
      w_next = MAX_P;
    end
  end

  // Position only moves on the frame boundary so pulses are never cut short.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pos <= MIN_P;
      r_pwm <= 1'b0;
    end else begin
      if (i_frame_tick) begin
        r_pos <= w_next;
      end
      r_pwm <= (i_us_cnt < frame_us_t'(r_pos));
    end
  end

  assign o_pos = r_pos;
  assign o_pwm = r_pwm;

endmodule

// File: rtl/gesture_servo_driver.sv
// Gesture-to-servo driver: decodes gesture codes into per-finger targets,
// latches them at frame boundaries and drives five 50 Hz hobby-servo PWMs.
//   clk, rst_n    : clock, synchronous active-low reset
//   gesture       : gesture code (bit i = finger i closed, bit 7 = hold)
//   gesture_valid : one-cycle strobe qualifying gesture
//   pwm           : servo PWM outputs, bit i drives finger i
//   frame_tick    : one-cycle pulse on the first cycle of each frame
//   busy          : high while any position (or pending target) differs
// Build option: define SERVO_SLEW_EN for slew-limited motion (STEP_US per
// frame); otherwise positions jump straight to their targets each frame.
module gesture_servo_driver
  import servo_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned PWM_HZ  = 50,
  parameter int unsigned MIN_US  = 1000,
  parameter int unsigned MAX_US  = 2000,
  parameter int unsigned STEP_US = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        gesture,
  input  logic              gesture_valid,
  output logic [NUM_CH-1:0] pwm,
  output logic              frame_tick,
  output logic              busy
);

  localparam int unsigned PRE_DIV  = CLK_HZ / 1_000_000;
  localparam int unsigned PRE_W    = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
  localparam int unsigned FRAME_US = 1_000_000 / PWM_HZ;

  // Direct mode is a single step spanning the full travel range.
`ifdef SERVO_SLEW_EN
  localparam int unsigned STEP_EFF = STEP_US;
`else
  localparam int unsigned STEP_EFF = MAX_US - MIN_US;
`endif

  localparam pos_us_t    MIN_P     = pos_us_t'(MIN_US);
  localparam pos_us_t    MAX_P     = pos_us_t'(MAX_US);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE_DIV - 1);
  localparam frame_us_t  FRAME_LAST = frame_us_t'(FRAME_US - 1);

  // Reject parameter sets the timebase or pulse range cannot represent.
  if ((CLK_HZ % 1_000_000) != 0 || PRE_DIV == 0 || MAX_US <= MIN_US ||
      MAX_US >= FRAME_US || STEP_US == 0) begin : g_bad_cfg
    $error("gesture_servo_driver: unsupported parameter set");
  end

  logic [PRE_W-1:0]  r_pre;
  frame_us_t         r_us_cnt;
  logic              r_frame_tick;
  pos_us_t           r_tgt    [NUM_CH];
  pos_us_t           r_shadow [NUM_CH];
  logic              r_pending;
  logic              r_busy;

  pos_us_t           w_new_tgt [NUM_CH];
  pos_us_t           w_eff_tgt [NUM_CH];
  pos_us_t           w_pos     [NUM_CH];
  logic [NUM_CH-1:0] w_pwm;
  logic              w_accept;
  logic              w_busy_c;
  logic              w_unused_gesture;

  assign w_unused_gesture = ^gesture[6:5];

  // Microsecond prescaler and frame counter; tick marks us_cnt becoming 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pre        <= '0;
      r_us_cnt     <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= 1'b0;
      if (r_pre == PRE_LAST) begin
        r_pre <= '0;
        if (r_us_cnt == FRAME_LAST) begin
          r_us_cnt     <= '0;
          r_frame_tick <= 1'b1;
        end else begin
          r_us_cnt <= r_us_cnt + frame_us_t'(1);
        end
      end else begin
        r_pre <= r_pre + PRE_W'(1);
      end
    end
  end

  assign w_accept = gesture_valid & ~gesture[HOLD_BIT];

  // Decode gesture bits; channels see the shadow if it lands this boundary.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_new_tgt[i] = gesture[i] ? MAX_P : MIN_P;
      w_eff_tgt[i] = r_pending ? r_shadow[i] : r_tgt[i];
    end
  end

  // Shadow capture (last wins) and target load at the frame boundary.
  // A capture on the tick cycle re-arms pending for the following frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_tgt[i]    <= MIN_P;
        r_shadow[i] <= MIN_P;
      end
      r_pending <= 1'b0;
    end else begin
      if (r_frame_tick && r_pending) begin
        r_tgt     <= r_shadow;
        r_pending <= 1'b0;
      end
      if (w_accept) begin
        r_shadow  <= w_new_tgt;
        r_pending <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    servo_pwm_channel #(
      .MIN_US  (MIN_US),
      .MAX_US  (MAX_US),
      .STEP_US (STEP_EFF)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_frame_tick (r_frame_tick),
      .i_tgt        (w_eff_tgt[i]),
      .i_us_cnt     (r_us_cnt),
      .o_pos        (w_pos[i]),
      .o_pwm        (w_pwm[i])
    );
  end

  // Busy covers motion in progress and a pending target not yet applied.
  always_comb begin
    w_busy_c = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_busy_c = w_busy_c | (w_pos[i] != r_tgt[i]) |
                 (r_pending & (r_shadow[i] != r_tgt[i]));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
    end else begin
      r_busy <= w_busy_c;
    end
  end

  assign pwm        = w_pwm;
  assign frame_tick = r_frame_tick;
  assign busy       = r_busy;

endmodule
